multdiv_iter: RTL and testbench

//  Parametrised iterative signed multiplier/divider for the processor execute stage.

---
 rtl/multdiv_iter.sv | 169 ++++++++++++++++
 tb/tb_multdiv_iter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative signed multiplier/divider: radix-2 Booth multiply and restoring divide,
// one step per cycle. A new start pulse aborts any operation already in flight.
module multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN_MULT, RUN_DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // hi holds the Booth upper half or the divider remainder; lo the multiplier or quotient
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   m_q, m_d;
    logic             qm1_q, qm1_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic [WIDTH:0]     booth_sum, booth_hi;
    logic [WIDTH-1:0]   booth_lo;
    logic [2*WIDTH-1:0] product;
    logic               mul_ovf;
    logic [WIDTH:0]     div_shift, div_rem;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH-1:0]   div_quo, quo_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               last;
    logic               div_zero;

    assign last     = (cnt_q == CNT_W'(WIDTH - 1));
    assign div_zero = (m_q == '0);
    assign abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Single-step Booth and restoring-divide datapaths
    always_comb begin
        booth_sum = hi_q;
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = hi_q + m_q;
            2'b10:   booth_sum = hi_q - m_q;
            default: booth_sum = hi_q;
        endcase
        booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo = {booth_sum[0], lo_q[WIDTH-1:1]};
        product  = {booth_hi[WIDTH-1:0], booth_lo};
        mul_ovf  = !((&product[2*WIDTH-1:WIDTH-1]) || ~(|product[2*WIDTH-1:WIDTH-1]));

        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, m_q};
        if (!div_diff[WIDTH+1]) begin
            div_rem = div_diff[WIDTH:0];
            div_quo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem = div_shift;
            div_quo = {lo_q[WIDTH-2:0], 1'b0};
        end
        quo_signed = neg_q ? -div_quo : div_quo;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_MULT)     state_d = RUN_MULT;
        else if (ctrl_DIV) state_d = RUN_DIV;
        else begin
            case (state_q)
                IDLE:     state_d = IDLE;
                RUN_MULT: if (last) state_d = DONE;
                RUN_DIV:  if (div_zero || last) state_d = DONE;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        m_d   = m_q;
        qm1_d = qm1_q;
        neg_d = neg_q;
        res_d = res_q;
        exc_d = exc_q;
        if (ctrl_MULT) begin
            cnt_d = '0;
            hi_d  = '0;
            lo_d  = data_operandB;
            m_d   = {data_operandA[WIDTH-1], data_operandA};
            qm1_d = 1'b0;
        end else if (ctrl_DIV) begin
            cnt_d = '0;
            hi_d  = '0;
            lo_d  = abs_a;
            m_d   = {1'b0, abs_b};
            neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end else if (state_q == RUN_MULT) begin
            cnt_d = cnt_q + CNT_W'(1);
            hi_d  = booth_hi;
            lo_d  = booth_lo;
            qm1_d = lo_q[0];
            if (last) begin
                res_d = product[WIDTH-1:0];
                exc_d = mul_ovf;
            end
        end else if (state_q == RUN_DIV) begin
            if (div_zero) begin
                res_d = '0;
                exc_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                hi_d  = div_rem;
                lo_d  = div_quo;
                if (last) begin
                    res_d = quo_signed;
                    // only MIN_INT / -1 yields a positive quotient with the MSB set
                    exc_d = ~neg_q & div_quo[WIDTH-1];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            qm1_q <= 1'b0;
            neg_q <= 1'b0;
            res_q <= '0;
            exc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            qm1_q <= qm1_d;
            neg_q <= neg_d;
            res_q <= res_d;
            exc_q <= exc_d;
        end
    end

    always_comb begin
        data_result    = res_q;
        data_exception = exc_q;
        data_resultRDY = (state_q == DONE);
        busy           = (state_q == RUN_MULT) || (state_q == RUN_DIV);
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter at WIDTH=32 and WIDTH=8: latency, busy window,
// results, exceptions, abort/restart and asynchronous reset.
module tb_multdiv_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m32 = 1'b0, d32 = 1'b0, m8 = 1'b0, d8 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [31:0] r32;
    logic        e32, rdy32, bsy32;
    logic [7:0]  r8;
    logic        e8, rdy8, bsy8;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    multdiv_iter #(.WIDTH(32)) u32 (
        .clock(clk), .reset(rst_n), .ctrl_MULT(m32), .ctrl_DIV(d32),
        .data_operandA(a32), .data_operandB(b32), .data_result(r32),
        .data_exception(e32), .data_resultRDY(rdy32), .busy(bsy32)
    );

    multdiv_iter #(.WIDTH(8)) u8 (
        .clock(clk), .reset(rst_n), .ctrl_MULT(m8), .ctrl_DIV(d8),
        .data_operandA(a8), .data_operandB(b8), .data_result(r8),
        .data_exception(e8), .data_resultRDY(rdy8), .busy(bsy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 with the operands scrambled.
    // op: 0 = MULT, 1 = DIV, 2 = both pulses together
    task automatic start_op(input bit w8, input int op, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            m8 = (op != 1); d8 = (op != 0); a8 = a[7:0]; b8 = b[7:0];
        end else begin
            m32 = (op != 1); d32 = (op != 0); a32 = a; b32 = b;
        end
        @(negedge clk);
        m32 = 1'b0; d32 = 1'b0; m8 = 1'b0; d8 = 1'b0;
        a32 = $urandom; b32 = $urandom;
        a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic wait_done(input bit w8, input string tag, input logic [31:0] er,
                             input logic ee, input int lat);
        int cyc;
        bit busy_ok;
        cyc = 1;
        busy_ok = 1'b1;
        while (!(w8 ? rdy8 : rdy32) && cyc < 100) begin
            if (!(w8 ? bsy8 : bsy32)) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".lat"}, 32'(cyc), 32'(lat));
        chk({tag, ".busy_run"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, ".busy_rdy"}, {31'b0, (w8 ? bsy8 : bsy32)}, 32'd0);
        if (w8) chk({tag, ".res"}, {24'b0, r8}, {24'b0, er[7:0]});
        else    chk({tag, ".res"}, r32, er);
        chk({tag, ".exc"}, {31'b0, (w8 ? e8 : e32)}, {31'b0, ee});
        @(negedge clk);
        chk({tag, ".rdy_pulse"}, {31'b0, (w8 ? rdy8 : rdy32)}, 32'd0);
    endtask

    initial begin
        int rdy_seen;
        #1;
        chk("rst.res", r32, 32'd0);
        chk("rst.exc", {31'b0, e32}, 32'd0);
        chk("rst.rdy", {31'b0, rdy32}, 32'd0);
        chk("rst.busy", {31'b0, bsy32}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 32-bit multiply
        start_op(0, 0, 32'd7, 32'hFFFF_FFFD);
        wait_done(0, "mul_7x-3", 32'hFFFF_FFEB, 1'b0, 33);
        start_op(0, 0, 32'h0001_0000, 32'h0001_0000);
        wait_done(0, "mul_ovf_pos", 32'h0000_0000, 1'b1, 33);
        start_op(0, 0, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done(0, "mul_-1xmin", 32'h8000_0000, 1'b1, 33);
        start_op(0, 0, 32'h8000_0000, 32'h8000_0000);
        wait_done(0, "mul_minxmin", 32'h0000_0000, 1'b1, 33);
        start_op(0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFF7);
        wait_done(0, "mul_-7x-9", 32'd63, 1'b0, 33);

        // 32-bit divide
        start_op(0, 1, 32'hFFFF_FF9C, 32'd7);
        wait_done(0, "div_-100/7", 32'hFFFF_FFF2, 1'b0, 33);
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, "div_min/-1", 32'h8000_0000, 1'b1, 33);
        start_op(0, 1, 32'd100, 32'hFFFF_FFF9);
        wait_done(0, "div_100/-7", 32'hFFFF_FFF2, 1'b0, 33);
        start_op(0, 1, 32'd7, 32'd100);
        wait_done(0, "div_7/100", 32'd0, 1'b0, 33);
        start_op(0, 1, 32'd5, 32'd0);
        wait_done(0, "div_by0", 32'd0, 1'b1, 2);
        start_op(0, 0, 32'd2, 32'd3);
        wait_done(0, "mul_after_by0", 32'd6, 1'b0, 33);

        // Abort: MULT at cycle 0, DIV pulsed in cycle 10, single RDY at cycle 43
        start_op(0, 0, 32'd9, 32'd9);
        rdy_seen = 0;
        for (int k = 1; k < 10; k++) begin
            if (rdy32) rdy_seen++;
            @(negedge clk);
        end
        start_op(0, 1, 32'd81, 32'd9);
        chk("abort.early_rdy", 32'(rdy_seen), 32'd0);
        wait_done(0, "abort_div", 32'd9, 1'b0, 33);
        rdy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (rdy32) rdy_seen++;
            @(negedge clk);
        end
        chk("abort.late_rdy", 32'(rdy_seen), 32'd0);

        start_op(0, 2, 32'd6, 32'd3);
        wait_done(0, "both_ctrl", 32'd18, 1'b0, 33);

        // Async reset in the middle of a multiply
        start_op(0, 0, 32'd7, 32'hFFFF_FFFD);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.res", r32, 32'd0);
        chk("midrst.exc", {31'b0, e32}, 32'd0);
        chk("midrst.rdy", {31'b0, rdy32}, 32'd0);
        chk("midrst.busy", {31'b0, bsy32}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (rdy32 || bsy32) rdy_seen++;
            @(negedge clk);
        end
        chk("midrst.no_rdy", 32'(rdy_seen), 32'd0);

        // 8-bit instance
        start_op(1, 0, 32'h07, 32'hFD);
        wait_done(1, "w8_mul_7x-3", 32'hEB, 1'b0, 9);
        start_op(1, 0, 32'h10, 32'h10);
        wait_done(1, "w8_mul_ovf", 32'h00, 1'b1, 9);
        start_op(1, 0, 32'hFF, 32'h80);
        wait_done(1, "w8_mul_-1xmin", 32'h80, 1'b1, 9);
        start_op(1, 1, 32'h9C, 32'h07);
        wait_done(1, "w8_div_-100/7", 32'hF2, 1'b0, 9);
        start_op(1, 1, 32'h80, 32'hFF);
        wait_done(1, "w8_div_min/-1", 32'h80, 1'b1, 9);
        start_op(1, 1, 32'h05, 32'h00);
        wait_done(1, "w8_div_by0", 32'h00, 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
